// File: rtl/fnd_time_scan.sv
// rtl/fnd_time_scan.sv - 4-digit 7-segment scan driver for msec/sec/min/hour time fields
module fnd_time_scan #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_msec,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hour,
    input  logic       i_mode,
    input  logic       i_half_sec,
    output logic [3:0] o_fnd_com,
    output logic [7:0] o_fnd_data
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [3:0] DIGIT_DASH = 4'hF;

    logic [CNT_W-1:0] prescaler;
    logic             scan_tick;
    logic [1:0]       sel;

    logic [6:0] msec_q;
    logic [5:0] sec_q;
    logic [5:0] min_q;
    logic [4:0] hour_q;
    logic       mode_q;

    logic [6:0] pair_val;
    logic [6:0] pair_max;
    logic [3:0] digit;
    logic [7:0] seg_next;

    assign scan_tick = (prescaler == CNT_W'(SCAN_DIV - 1));

    // Snapshot is taken on the last tick of a frame so all four digits show one coherent time.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            sel       <= 2'd0;
            msec_q    <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            mode_q    <= 1'b0;
        end else begin
            prescaler <= scan_tick ? '0 : prescaler + CNT_W'(1);
            if (scan_tick) begin
                sel <= sel + 2'd1;
            end
            if (scan_tick && sel == 2'd3) begin
                msec_q <= i_msec;
                sec_q  <= i_sec;
                min_q  <= i_min;
                hour_q <= i_hour;
                mode_q <= i_mode;
            end
        end
    end

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hBF;
        endcase
    endfunction

    // sel[1] picks the upper (sec/hour) or lower (msec/min) pair; sel[0] picks tens vs ones.
    always_comb begin
        pair_val = '0;
        pair_max = '0;
        case ({mode_q, sel[1]})
            2'b00: begin pair_val = msec_q;          pair_max = 7'd99; end
            2'b01: begin pair_val = {1'b0, sec_q};   pair_max = 7'd59; end
            2'b10: begin pair_val = {1'b0, min_q};   pair_max = 7'd59; end
            default: begin pair_val = {2'b0, hour_q}; pair_max = 7'd23; end
        endcase
        if (pair_val > pair_max) begin
            digit = DIGIT_DASH;
        end else if (sel[0]) begin
            digit = 4'(pair_val / 7'd10);
        end else begin
            digit = 4'(pair_val % 7'd10);
        end
        seg_next = seg_code(digit);
        if (sel == 2'd2 && i_half_sec) begin
            seg_next[7] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_fnd_com  <= 4'b1111;
            o_fnd_data <= 8'hFF;
        end else begin
            o_fnd_com  <= ~(4'b0001 << sel);
            o_fnd_data <= seg_next;
        end
    end
endmodule

// File: tb/tb_fnd_time_scan.sv
// tb/tb_fnd_time_scan.sv - self-checking bench for fnd_time_scan with frame-level reference model
module tb_fnd_time_scan;
    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    logic       clk;
    logic       rst;
    logic [6:0] i_msec;
    logic [5:0] i_sec;
    logic [5:0] i_min;
    logic [4:0] i_hour;
    logic       i_mode;
    logic       i_half_sec;
    logic [3:0] o_fnd_com;
    logic [7:0] o_fnd_data;

    int tests;
    int fails;

    // Reference state: edges since reset release and the values latched for the current frame.
    int k;
    int s_ms, s_sec, s_min, s_hr, s_md;

    typedef struct {
        int          ms;
        int          sec;
        int          mn;
        int          hr;
        bit          md;
        bit          half;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    fnd_time_scan #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_msec     (i_msec),
        .i_sec      (i_sec),
        .i_min      (i_min),
        .i_hour     (i_hour),
        .i_mode     (i_mode),
        .i_half_sec (i_half_sec),
        .o_fnd_com  (o_fnd_com),
        .o_fnd_data (o_fnd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] m_seg(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    function automatic logic [7:0] m_digit(input int s, input bit half);
        int v;
        int lim;
        logic [7:0] r;
        if (s >= 2) begin
            v   = s_md ? s_hr : s_sec;
            lim = s_md ? 23 : 59;
        end else begin
            v   = s_md ? s_min : s_ms;
            lim = s_md ? 59 : 99;
        end
        if (v > lim) r = 8'hBF;
        else         r = m_seg((s % 2 == 1) ? v / 10 : v % 10);
        if (s == 2 && half) r[7] = 1'b0;
        return r;
    endfunction

    task automatic tick(input bit do_chk);
        logic [3:0] ec;
        logic [7:0] ed;
        int s;
        if (rst) begin
            ec = 4'b1111;
            ed = 8'hFF;
            k = 0;
            s_ms = 0; s_sec = 0; s_min = 0; s_hr = 0; s_md = 0;
        end else begin
            s  = (k / SD) % 4;
            ec = ~(4'b0001 << s);
            ed = m_digit(s, i_half_sec);
            if (k % FRAME == FRAME - 1) begin
                s_ms = int'(i_msec); s_sec = int'(i_sec); s_min = int'(i_min);
                s_hr = int'(i_hour); s_md = int'(i_mode);
            end
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        if (do_chk) begin
            tests++;
            if (o_fnd_com !== ec || o_fnd_data !== ed) begin
                fails++;
                $display("FAIL model k=%0d: com=%b data=%h, expected com=%b data=%h",
                         k, o_fnd_com, o_fnd_data, ec, ed);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] ec, input logic [7:0] ed);
        tests++;
        if (o_fnd_com !== ec || o_fnd_data !== ed) begin
            fails++;
            $display("FAIL %s: com=%b data=%h, expected com=%b data=%h",
                     nm, o_fnd_com, o_fnd_data, ec, ed);
        end
    endtask

    // Advance until a new snapshot has been taken and the next edge starts a frame.
    task automatic align();
        tick(1);
        for (int i = 0; i < FRAME && (k % FRAME) != 0; i++) tick(1);
    endtask

    task automatic set_in(input int ms, input int sec, input int mn, input int hr,
                          input bit md, input bit half);
        i_msec = 7'(ms); i_sec = 6'(sec); i_min = 6'(mn); i_hour = 5'(hr);
        i_mode = md; i_half_sec = half;
    endtask

    initial begin
        logic [3:0] ec;
        tests = 0; fails = 0; k = 0;
        s_ms = 0; s_sec = 0; s_min = 0; s_hr = 0; s_md = 0;

        vecs[0] = '{7,   42, 0,  0,  1'b0, 1'b0, 32'h99A4C0F8};
        vecs[1] = '{0,   0,  5,  23, 1'b1, 1'b1, 32'hA430C092};
        vecs[2] = '{99,  60, 0,  0,  1'b0, 1'b0, 32'hBFBF9090};
        vecs[3] = '{0,   0,  59, 24, 1'b1, 1'b0, 32'hBFBF9290};
        vecs[4] = '{100, 0,  0,  0,  1'b0, 1'b1, 32'hC040BFBF};
        vecs[5] = '{0,   0,  60, 9,  1'b1, 1'b0, 32'hC090BFBF};

        // Reset release and scan order.
        set_in(0, 0, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("reset_blank", 4'b1111, 8'hFF);
        end
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick(1);
            if (i % 4 == 0 || i == 3) begin
                ec = ~(4'b0001 << ((i / 4) % 4));
                chk($sformatf("release_scan_%0d", i), ec, 8'hC0);
            end
        end

        // Table-driven display frames.
        for (int v = 0; v < 6; v++) begin
            set_in(vecs[v].ms, vecs[v].sec, vecs[v].mn, vecs[v].hr, vecs[v].md, vecs[v].half);
            align();
            for (int j = 0; j < FRAME; j++) begin
                tick(1);
                if (j % SD == 0) begin
                    ec = ~(4'b0001 << (j / SD));
                    chk($sformatf("vec%0d_d%0d", v, j / SD), ec, vecs[v].exp[8 * (j / SD) +: 8]);
                end
            end
        end

        // DP follows half_sec within one clock.
        set_in(0, 0, 5, 23, 1'b1, 1'b1);
        align();
        for (int j = 0; j < 9; j++) tick(1);
        chk("dp_on", 4'b1011, 8'h30);
        i_half_sec = 1'b0;
        tick(1);
        chk("dp_off", 4'b1011, 8'hB0);

        // Input change mid-frame stays hidden until the frame boundary.
        set_in(19, 0, 0, 0, 1'b0, 1'b0);
        align();
        tick(1);
        chk("snap_d0_19", 4'b1110, 8'h90);
        for (int j = 1; j < SD; j++) tick(1);
        i_msec = 7'd20;
        tick(1);
        chk("snap_d1_19", 4'b1101, 8'hF9);
        for (int j = SD + 1; j < FRAME; j++) tick(1);
        tick(1);
        chk("snap_d0_20", 4'b1110, 8'hC0);
        for (int j = 1; j < SD; j++) tick(1);
        tick(1);
        chk("snap_d1_20", 4'b1101, 8'hA4);

        // Reset mid-frame clears snapshot and restarts the scan.
        set_in(7, 42, 0, 0, 1'b0, 1'b0);
        align();
        for (int j = 0; j < 2 * SD; j++) tick(1);
        rst = 1'b1;
        tick(1);
        chk("midrst_blank", 4'b1111, 8'hFF);
        rst = 1'b0;
        tick(1);
        chk("midrst_restart", 4'b1110, 8'hC0);
        for (int j = 1; j < SD; j++) tick(1);
        tick(1);
        chk("midrst_d1", 4'b1101, 8'hC0);

        // Random traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                i_msec = 7'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 99));
                i_sec  = 6'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)  : $urandom_range(0, 59));
                i_min  = 6'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)  : $urandom_range(0, 59));
                i_hour = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)  : $urandom_range(0, 23));
                i_mode = 1'($urandom_range(0, 1));
            end
            i_half_sec = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 149) == 0);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
